// File: rtl/dpe_pkg.sv
// Shared DPE definitions: port indices, arbiter states and the modulo-wrap helper.
package dpe_pkg;

    localparam int DPE_NUM_PORTS = 5;
    localparam int DPE_ID_W      = $clog2(DPE_NUM_PORTS);

    typedef logic [DPE_ID_W-1:0] port_idx_t;

    typedef enum logic [DPE_ID_W-1:0] {
        PORT_CPU  = 3'd0,
        PORT_ETH1 = 3'd1,
        PORT_ETH2 = 3'd2,
        PORT_ETH3 = 3'd3,
        PORT_ETH4 = 3'd4
    } port_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_XFER = 1'b1
    } arb_state_e;

    // Operands never exceed 2*n-1, so a single compare-and-subtract is a full modulo.
    function automatic int unsigned wrap_idx(input int unsigned sum, input int unsigned n);
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/dpe_rr_pick.sv
// Combinational rotate-priority encoder: first requester after ptr, wrapping modulo NUM_PORTS.
module dpe_rr_pick
    import dpe_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_W-1:0]      ptr,
    output logic                 any,
    output logic [ID_W-1:0]      idx
);

    logic [ID_W-1:0] cand;

    // Scan farthest-first so the nearest requester after ptr is the last one written.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand = ID_W'(wrap_idx(int'(ptr) + k, NUM_PORTS));
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/dpe_ingress_arb.sv
// Packet-level round-robin merge of the DPE ingress streams into one DPE input stream.
// Optional per-port packet counters (pkt_cnt, stats_clr) are built when DPE_ARB_STATS_EN is defined.
module dpe_ingress_arb
    import dpe_pkg::*;
#(
    parameter int NUM_PORTS = DPE_NUM_PORTS,
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        pause,
    output logic                        is_idle,
    input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]        s_tvalid,
    input  logic [NUM_PORTS-1:0]        s_tlast,
    output logic [NUM_PORTS-1:0]        s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic [KEEP_W-1:0]           m_tkeep,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    input  logic                        m_tready,
    output logic [ID_W-1:0]             m_tid
`ifdef DPE_ARB_STATS_EN
    ,
    input  logic                        stats_clr,
    output logic [NUM_PORTS*32-1:0]     pkt_cnt
`endif
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            pick_any;
    logic [ID_W-1:0] pick_idx;
    logic            eop_hs;

    dpe_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_W      (ID_W)
    ) u_pick (
        .req (s_tvalid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_PORTS - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        eop_hs   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!pause && pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                m_tdata           = s_tdata[DATA_W*int'(grant_q) +: DATA_W];
                m_tkeep           = s_tkeep[KEEP_W*int'(grant_q) +: KEEP_W];
                m_tvalid          = s_tvalid[grant_q];
                m_tlast           = s_tlast[grant_q];
                s_tready[grant_q] = m_tready;
                eop_hs            = m_tvalid & m_tready & m_tlast;
                // Returning to IDLE forces one bubble between packets.
                if (eop_hs) begin
                    rr_ptr_d = grant_q;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign is_idle = (state_q == ARB_IDLE);
    assign m_tid   = grant_q;

`ifdef DPE_ARB_STATS_EN
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
        logic [31:0] cnt_q;

        // Clear wins over a same-cycle increment.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                cnt_q <= '0;
            end else if (stats_clr) begin
                cnt_q <= '0;
            end else if (eop_hs && (grant_q == ID_W'(i))) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign pkt_cnt[i*32 +: 32] = cnt_q;
    end
`endif

endmodule
